// File: rtl/sdu_tx_seq.sv
// TX sequence buffer/player: samples are appended to an inferred RAM while idle,
// then replayed to the DAC at a programmable rate for N passes or until aborted.
module sdu_tx_seq #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] sdu_tx_data,
    input  logic              sdu_tx_strobe,
    input  logic              wr_clear,
    input  logic              start,
    input  logic              abort,
    input  logic [CNTW-1:0]   rate_div,
    input  logic [CNTW-1:0]   num_reps,
    output logic              sdu_tx_en,
    output logic              dac_strobe,
    output logic              sdu_rep_done_strobe,
    output logic              sdu_seq_done_strobe,
    output logic              sdu_abort_strobe,
    output logic [AWIDTH:0]   seq_len,
    output logic              overflow,
    output logic              busy,
    output logic [DWIDTH-1:0] dac_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PLAY = 2'd2} state_t;

    localparam logic [AWIDTH:0]   LEN_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] IDX_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]   CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem_r [0:(2**AWIDTH)-1];
    logic [DWIDTH-1:0] rd_data_r;
    logic [AWIDTH-1:0] rd_addr_s;
    state_t            state_r;
    state_t            next_state_s;
    logic [AWIDTH-1:0] idx_r;
    logic [CNTW-1:0]   hold_r;
    logic [CNTW-1:0]   pass_r;
    logic [CNTW-1:0]   rate_r;
    logic [CNTW-1:0]   reps_r;
    logic              idle_s;
    logic              wr_req_s;
    logic              wr_en_s;
    logic              start_ok_s;
    logic              last_hold_s;
    logic              last_idx_s;
    logic              pass_end_s;
    logic              final_s;
    logic [AWIDTH-1:0] next_idx_s;
    logic              tx_en_s;
    logic              dac_strobe_s;
    logic              rep_done_s;
    logic              seq_done_s;
    logic              abort_strobe_s;
    logic [DWIDTH-1:0] dac_s;

    // Shared control decodes for the write path and the playback cursor
    always_comb begin
        idle_s      = (state_r == IDLE);
        wr_req_s    = idle_s && sdu_tx_strobe && !wr_clear;
        wr_en_s     = wr_req_s && !seq_len[AWIDTH];
        start_ok_s  = idle_s && start && !abort && (seq_len != {(AWIDTH+1){1'b0}});
        last_hold_s = (hold_r == rate_r);
        last_idx_s  = ({1'b0, idx_r} == (seq_len - LEN_ONE));
        pass_end_s  = (state_r == PLAY) && last_hold_s && last_idx_s;
        final_s     = pass_end_s && (reps_r != {CNTW{1'b0}}) && ((pass_r + CNT_ONE) == reps_r);
        if (last_idx_s) begin
            next_idx_s = {AWIDTH{1'b0}};
        end else begin
            next_idx_s = idx_r + IDX_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort always wins over start and end-of-sequence
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) next_state_s = FILL;
                else            next_state_s = IDLE;
            end
            FILL: begin
                if (abort) next_state_s = IDLE;
                else       next_state_s = PLAY;
            end
            PLAY: begin
                if (abort || final_s) next_state_s = IDLE;
                else                  next_state_s = PLAY;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode; the cursor runs one cycle ahead of the registered DAC outputs
    always_comb begin
        rd_addr_s      = {AWIDTH{1'b0}};
        tx_en_s        = 1'b0;
        dac_strobe_s   = 1'b0;
        rep_done_s     = 1'b0;
        seq_done_s     = 1'b0;
        abort_strobe_s = 1'b0;
        dac_s          = {DWIDTH{1'b0}};
        case (state_r)
            PLAY: begin
                if (last_hold_s) rd_addr_s = next_idx_s;
                else             rd_addr_s = idx_r;
                if (abort) begin
                    abort_strobe_s = 1'b1;
                end else begin
                    tx_en_s      = 1'b1;
                    dac_s        = rd_data_r;
                    dac_strobe_s = (hold_r == {CNTW{1'b0}});
                    rep_done_s   = pass_end_s;
                    seq_done_s   = final_s;
                end
            end
            FILL: begin
                if (abort) abort_strobe_s = 1'b1;
                else       abort_strobe_s = 1'b0;
            end
            IDLE:    rd_addr_s = {AWIDTH{1'b0}};
            default: rd_addr_s = {AWIDTH{1'b0}};
        endcase
    end

    // Playback cursor: sample index, hold counter, pass counter, latched settings
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r  <= {AWIDTH{1'b0}};
            hold_r <= {CNTW{1'b0}};
            pass_r <= {CNTW{1'b0}};
            rate_r <= {CNTW{1'b0}};
            reps_r <= {CNTW{1'b0}};
        end else if (start_ok_s) begin
            idx_r  <= {AWIDTH{1'b0}};
            hold_r <= {CNTW{1'b0}};
            pass_r <= {CNTW{1'b0}};
            rate_r <= rate_div;
            reps_r <= num_reps;
        end else if (state_r == PLAY) begin
            if (last_hold_s) begin
                hold_r <= {CNTW{1'b0}};
                idx_r  <= next_idx_s;
            end else begin
                hold_r <= hold_r + CNT_ONE;
            end
            if (pass_end_s) pass_r <= pass_r + CNT_ONE;
        end
    end

    // Write pointer (low bits of seq_len) and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_len  <= {(AWIDTH+1){1'b0}};
            overflow <= 1'b0;
        end else if (idle_s && wr_clear) begin
            seq_len  <= {(AWIDTH+1){1'b0}};
            overflow <= 1'b0;
        end else if (wr_en_s) begin
            seq_len <= seq_len + LEN_ONE;
        end else if (wr_req_s) begin
            overflow <= 1'b1;
        end
    end

    // Sample RAM with registered read
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[seq_len[AWIDTH-1:0]] <= sdu_tx_data;
        rd_data_r <= mem_r[rd_addr_s];
    end

    // Registered outputs; busy also covers the final sample still on the DAC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdu_tx_en           <= 1'b0;
            dac_strobe          <= 1'b0;
            sdu_rep_done_strobe <= 1'b0;
            sdu_seq_done_strobe <= 1'b0;
            sdu_abort_strobe    <= 1'b0;
            busy                <= 1'b0;
            dac_out             <= {DWIDTH{1'b0}};
        end else begin
            sdu_tx_en           <= tx_en_s;
            dac_strobe          <= dac_strobe_s;
            sdu_rep_done_strobe <= rep_done_s;
            sdu_seq_done_strobe <= seq_done_s;
            sdu_abort_strobe    <= abort_strobe_s;
            busy                <= (next_state_s != IDLE) || tx_en_s;
            dac_out             <= dac_s;
        end
    end
endmodule

// File: tb/tb_sdu_tx_seq.sv
// Directed bench for sdu_tx_seq (AWIDTH=4 so the full-RAM and overflow cases are short).
module tb_sdu_tx_seq;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] sdu_tx_data;
    logic          sdu_tx_strobe;
    logic          wr_clear;
    logic          start;
    logic          abort;
    logic [CW-1:0] rate_div;
    logic [CW-1:0] num_reps;
    logic          sdu_tx_en;
    logic          dac_strobe;
    logic          sdu_rep_done_strobe;
    logic          sdu_seq_done_strobe;
    logic          sdu_abort_strobe;
    logic [AW:0]   seq_len;
    logic          overflow;
    logic          busy;
    logic [DW-1:0] dac_out;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] samp [0:15];

    sdu_tx_seq #(.DWIDTH(DW), .AWIDTH(AW), .CNTW(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .sdu_tx_data         (sdu_tx_data),
        .sdu_tx_strobe       (sdu_tx_strobe),
        .wr_clear            (wr_clear),
        .start               (start),
        .abort               (abort),
        .rate_div            (rate_div),
        .num_reps            (num_reps),
        .sdu_tx_en           (sdu_tx_en),
        .dac_strobe          (dac_strobe),
        .sdu_rep_done_strobe (sdu_rep_done_strobe),
        .sdu_seq_done_strobe (sdu_seq_done_strobe),
        .sdu_abort_strobe    (sdu_abort_strobe),
        .seq_len             (seq_len),
        .overflow            (overflow),
        .busy                (busy),
        .dac_out             (dac_out)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_sample(input logic [DW-1:0] d);
        @(negedge clk);
        sdu_tx_data   = d;
        sdu_tx_strobe = 1'b1;
        @(negedge clk);
        sdu_tx_strobe = 1'b0;
    endtask

    task automatic clear_seq();
        @(negedge clk);
        wr_clear = 1'b1;
        @(negedge clk);
        wr_clear = 1'b0;
    endtask

    // Cycle c=0 is the cycle after the start edge; active sample k appears at c=k+2.
    task automatic play_run(input string tag, input int nsamp, input int rd, input int reps,
                            input int ncyc, input int abort_c, input bit disturb);
        int total;
        int k;
        logic [20:0] exp_v;
        logic [20:0] got_v;
        total = (reps == 0) ? (1 << 30) : nsamp * (rd + 1) * reps;
        @(negedge clk);
        rate_div = 16'(rd);
        num_reps = 16'(reps);
        start    = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start         = 1'b0;
            abort         = 1'b0;
            sdu_tx_strobe = 1'b0;
            wr_clear      = 1'b0;
            if (c == 0) check_vec({tag, "_busy_start"}, 32'(busy), 32'd1);
            k = c - 2;
            exp_v = 21'd0;
            if (abort_c >= 0 && c == abort_c + 1) exp_v[20] = 1'b1;
            if (k >= 0 && k < total && (abort_c < 0 || c <= abort_c)) begin
                exp_v[15:0] = samp[(k / (rd + 1)) % nsamp];
                exp_v[16]   = 1'b1;
                exp_v[17]   = ((k % (rd + 1)) == 0);
                exp_v[18]   = (((k + 1) % (nsamp * (rd + 1))) == 0);
                exp_v[19]   = (k == total - 1);
            end
            got_v = {sdu_abort_strobe, sdu_seq_done_strobe, sdu_rep_done_strobe,
                     dac_strobe, sdu_tx_en, dac_out};
            check_vec($sformatf("%s_c%0d", tag, c), 32'(got_v), 32'(exp_v));
            if (c == abort_c) abort = 1'b1;
            if (disturb) begin
                case (c)
                    3:       sdu_tx_strobe = 1'b1;
                    4:       wr_clear = 1'b1;
                    5:       start = 1'b1;
                    6:       begin rate_div = 16'd5; num_reps = 16'd1; end
                    default: sdu_tx_strobe = 1'b0;
                endcase
            end
        end
        check_vec({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        sdu_tx_data   = 16'd0;
        sdu_tx_strobe = 1'b0;
        wr_clear      = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        rate_div      = 16'd0;
        num_reps      = 16'd0;
        for (int i = 0; i < 16; i++) samp[i] = 16'(i + 1);

        repeat (3) @(negedge clk);
        check_vec("rst_outs", 32'({busy, sdu_tx_en, dac_strobe, overflow, sdu_abort_strobe,
                                   sdu_rep_done_strobe, sdu_seq_done_strobe}), 32'd0);
        check_vec("rst_seq_len", 32'(seq_len), 32'd0);
        check_vec("rst_dac_out", 32'(dac_out), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) write_sample(samp[i]);
        @(negedge clk);
        check_vec("load4_len", 32'(seq_len), 32'd4);
        check_vec("load4_ovf", 32'(overflow), 32'd0);

        play_run("r0n1", 4, 0, 1, 8, -1, 1'b0);
        play_run("r2n3", 4, 2, 3, 40, -1, 1'b0);
        play_run("dist", 4, 1, 2, 20, -1, 1'b1);
        @(negedge clk);
        check_vec("dist_len", 32'(seq_len), 32'd4);

        // start together with abort while idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_vec("stab_busy", 32'(busy), 32'd0);
        check_vec("stab_astb", 32'(sdu_abort_strobe), 32'd0);
        @(negedge clk);
        check_vec("stab_busy2", 32'(busy), 32'd0);
        check_vec("stab_txen", 32'(sdu_tx_en), 32'd0);

        clear_seq();
        for (int i = 0; i < 3; i++) write_sample(samp[i]);
        play_run("loop_abort", 3, 0, 0, 15, 11, 1'b0);

        clear_seq();
        for (int i = 0; i < 17; i++) write_sample(samp[i % 16]);
        @(negedge clk);
        check_vec("full_len", 32'(seq_len), 32'd16);
        check_vec("full_ovf", 32'(overflow), 32'd1);
        play_run("fullram", 16, 0, 2, 36, -1, 1'b0);

        clear_seq();
        check_vec("clr_len", 32'(seq_len), 32'd0);
        check_vec("clr_ovf", 32'(overflow), 32'd0);

        rate_div = 16'd0;
        num_reps = 16'd1;
        start    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_vec($sformatf("empty_start_c%0d", c), 32'({busy, sdu_tx_en, sdu_abort_strobe}), 32'd0);
        end

        for (int i = 0; i < 4; i++) write_sample(samp[i]);
        @(negedge clk);
        num_reps = 16'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_vec("pre_rst_txen", 32'(sdu_tx_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_vec("arst_txen", 32'(sdu_tx_en), 32'd0);
        check_vec("arst_dac", 32'(dac_out), 32'd0);
        check_vec("arst_busy", 32'(busy), 32'd0);
        check_vec("arst_len", 32'(seq_len), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_vec("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
